// File: rtl/wide_mem_pkg.sv
// Shared definitions for the wide-memory write packer: lane geometry, FSM states
// and the byte-lane strobe helper.
package wide_mem_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int LANE_W         = 2;

  typedef enum logic {S_RUN, S_FLUSH} pack_state_t;

  function automatic logic [BYTES_PER_WORD-1:0] lane_onehot(input logic [LANE_W-1:0] lane);
    logic [BYTES_PER_WORD-1:0] oh;
    oh       = '0;
    oh[lane] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wide_wr_outreg.sv
// Output word register for the wide write port: holds address/data/strobes stable
// while mem_we is high until the memory accepts them.
module wide_wr_outreg
  import wide_mem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        load,
  input  logic [AW-1:0]               ld_addr,
  input  logic [31:0]                 ld_data,
  input  logic [BYTES_PER_WORD-1:0]   ld_strb,
  input  logic                        mem_ready,
  output logic                        mem_we,
  output logic [AW-1:0]               mem_waddr,
  output logic [31:0]                 mem_wdata,
  output logic [BYTES_PER_WORD-1:0]   mem_wstrb,
  output logic                        busy
);

  logic                      out_v_q, out_v_d;
  logic [AW-1:0]             addr_q, addr_d;
  logic [31:0]               data_q, data_d;
  logic [BYTES_PER_WORD-1:0] strb_q, strb_d;
  logic [31:0]               masked_data;

  // Disabled lanes are forced to zero so the memory never sees stale bytes.
  for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_mask
    assign masked_data[8*gi +: 8] = ld_strb[gi] ? ld_data[8*gi +: 8] : 8'h00;
  end

  assign busy = out_v_q && !mem_ready;

  always_comb begin
    out_v_d = out_v_q;
    addr_d  = addr_q;
    data_d  = data_q;
    strb_d  = strb_q;
    if (load && !busy) begin
      out_v_d = 1'b1;
      addr_d  = ld_addr;
      data_d  = masked_data;
      strb_d  = ld_strb;
    end else if (out_v_q && mem_ready) begin
      out_v_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_v_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      strb_q  <= '0;
    end else begin
      out_v_q <= out_v_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      strb_q  <= strb_d;
    end
  end

  assign mem_we    = out_v_q;
  assign mem_waddr = addr_q;
  assign mem_wdata = data_q;
  assign mem_wstrb = strb_q;

endmodule

// File: rtl/wide_write_packer.sv
// Merges a byte-wide write stream into 32-bit word writes with byte strobes;
// a flush pulse drains the partially filled word at end of frame.
module wide_write_packer
  import wide_mem_pkg::*;
#(
  parameter int AW = 10
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_we,
  input  logic [AW+1:0]             in_waddr,
  input  logic [7:0]                in_wdata,
  output logic                      in_ready,
  input  logic                      flush,
  output logic                      flush_done,
  output logic [AW-1:0]             mem_waddr,
  output logic [31:0]               mem_wdata,
  output logic [BYTES_PER_WORD-1:0] mem_wstrb,
  output logic                      mem_we,
  input  logic                      mem_ready,
  output logic [31:0]               o_byte_count,
  output logic [31:0]               o_word_wr_count
);

  pack_state_t               state_q, state_d;
  logic                      ready_en_q, ready_en_d;
  logic                      acc_v_q, acc_v_d;
  logic [AW-1:0]             acc_addr_q, acc_addr_d;
  logic [31:0]               acc_data_q, acc_data_d;
  logic [BYTES_PER_WORD-1:0] acc_strb_q, acc_strb_d;
  logic [31:0]               byte_cnt_q, byte_cnt_d;
  logic [31:0]               word_cnt_q, word_cnt_d;

  logic                      out_busy;
  logic                      accept;
  logic                      hit;
  logic                      acc_full;
  logic [AW-1:0]             in_word;
  logic [LANE_W-1:0]         in_lane;
  logic [31:0]               fresh_data;
  logic [BYTES_PER_WORD-1:0] fresh_strb;
  logic [31:0]               merge_data;
  logic [BYTES_PER_WORD-1:0] merge_strb;
  logic                      ld_en;
  logic [AW-1:0]             ld_addr;
  logic [31:0]               ld_data;
  logic [BYTES_PER_WORD-1:0] ld_strb;

  assign in_word    = in_waddr[AW+1:LANE_W];
  assign in_lane    = in_waddr[LANE_W-1:0];
  assign fresh_strb = lane_onehot(in_lane);
  assign fresh_data = {24'h0, in_wdata} << {in_lane, 3'b000};
  assign merge_strb = acc_strb_q | fresh_strb;
  assign acc_full   = &acc_strb_q;
  assign hit        = acc_v_q && (in_word == acc_addr_q);

  // ready_en_q keeps in_ready low until the first clock after reset release.
  assign in_ready   = ready_en_q && (state_q == S_RUN) && !out_busy;
  assign accept     = in_we && in_ready;
  assign flush_done = (state_q == S_FLUSH) && !acc_v_q && !mem_we;
  assign ready_en_d = 1'b1;

  always_comb begin
    state_d    = state_q;
    acc_v_d    = acc_v_q;
    acc_addr_d = acc_addr_q;
    acc_data_d = acc_data_q;
    acc_strb_d = acc_strb_q;
    ld_en      = 1'b0;
    ld_addr    = acc_addr_q;
    ld_data    = acc_data_q;
    ld_strb    = acc_strb_q;
    merge_data = acc_data_q;
    merge_data[{in_lane, 3'b000} +: 8] = in_wdata;

    if (state_q == S_RUN) begin
      if (accept) begin
        if (!acc_v_q || !hit) begin
          // A byte for another word evicts the current accumulator.
          ld_en      = acc_v_q;
          acc_v_d    = 1'b1;
          acc_addr_d = in_word;
          acc_data_d = fresh_data;
          acc_strb_d = fresh_strb;
        end else if (acc_full) begin
          ld_en   = 1'b1;
          ld_data = merge_data;
          ld_strb = merge_strb;
          acc_v_d = 1'b0;
        end else begin
          acc_data_d = merge_data;
          acc_strb_d = merge_strb;
        end
      end else if (acc_v_q && acc_full && !out_busy) begin
        ld_en   = 1'b1;
        acc_v_d = 1'b0;
      end
      if (flush) begin
        state_d = S_FLUSH;
      end
    end else begin
      if (acc_v_q && !out_busy) begin
        ld_en   = 1'b1;
        acc_v_d = 1'b0;
      end
      if (flush_done) begin
        state_d = S_RUN;
      end
    end
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q + {31'h0, accept};
    word_cnt_d = word_cnt_q + {31'h0, mem_we && mem_ready};
    if (flush_done) begin
      byte_cnt_d = '0;
      word_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_RUN;
      ready_en_q <= 1'b0;
      acc_v_q    <= 1'b0;
      acc_addr_q <= '0;
      acc_data_q <= '0;
      acc_strb_q <= '0;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ready_en_q <= ready_en_d;
      acc_v_q    <= acc_v_d;
      acc_addr_q <= acc_addr_d;
      acc_data_q <= acc_data_d;
      acc_strb_q <= acc_strb_d;
      byte_cnt_q <= byte_cnt_d;
      word_cnt_q <= word_cnt_d;
    end
  end

  wide_wr_outreg #(.AW(AW)) u_outreg (
    .clk       (clk),
    .rst       (rst),
    .load      (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .ld_strb   (ld_strb),
    .mem_ready (mem_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .busy      (out_busy)
  );

  assign o_byte_count    = byte_cnt_q;
  assign o_word_wr_count = word_cnt_q;

endmodule

// File: tb/tb_wide_write_packer.sv
// Scoreboard bench for wide_write_packer: a byte-grouping reference model pushes
// expected words, a negedge monitor pops and compares every memory handshake.
module tb_wide_write_packer;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_we;
  logic [AW+1:0] in_waddr;
  logic [7:0]    in_wdata;
  logic          in_ready;
  logic          flush;
  logic          flush_done;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_we;
  logic          mem_ready;
  logic [31:0]   o_byte_count;
  logic [31:0]   o_word_wr_count;

  always #5 clk = ~clk;

  wide_write_packer #(.AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_we           (in_we),
    .in_waddr        (in_waddr),
    .in_wdata        (in_wdata),
    .in_ready        (in_ready),
    .flush           (flush),
    .flush_done      (flush_done),
    .mem_waddr       (mem_waddr),
    .mem_wdata       (mem_wdata),
    .mem_wstrb       (mem_wstrb),
    .mem_we          (mem_we),
    .mem_ready       (mem_ready),
    .o_byte_count    (o_byte_count),
    .o_word_wr_count (o_word_wr_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
    logic [3:0]    strb;
  } word_t;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  word_t         exp_q[$];
  bit            m_open;
  logic [AW-1:0] m_addr;
  logic [7:0]    m_byte[4];
  bit            m_set[4];
  bit            flushing;
  int unsigned   m_bcnt, m_wcnt;
  int            fd_cnt, fd_cyc, hs_cyc, hs_cnt;
  logic [31:0]   fd_bytes, fd_words;
  word_t         last_wr;
  bit            stall;
  logic [46:0]   stall_snap;

  always @(posedge clk) cyc++;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void close_word();
    word_t w;
    w.addr = m_addr;
    w.data = '0;
    w.strb = '0;
    for (int k = 0; k < 4; k++) begin
      if (m_set[k]) begin
        w.data[8*k +: 8] = m_byte[k];
        w.strb[k]        = 1'b1;
      end
      m_set[k] = 1'b0;
    end
    exp_q.push_back(w);
    m_open = 1'b0;
  endfunction

  function automatic bit model_full();
    return m_open && m_set[0] && m_set[1] && m_set[2] && m_set[3];
  endfunction

  function automatic void model_put(logic [AW-1:0] w, logic [1:0] ln, logic [7:0] d);
    if (!(m_open && w == m_addr)) begin
      if (m_open) close_word();
      m_open = 1'b1;
      m_addr = w;
    end
    m_byte[ln] = d;
    m_set[ln]  = 1'b1;
  endfunction

  // Monitor and reference model: all sampling happens on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_open   = 1'b0;
      for (int k = 0; k < 4; k++) m_set[k] = 1'b0;
      flushing = 1'b0;
      m_bcnt   = 0;
      m_wcnt   = 0;
      stall    = 1'b0;
    end else begin
      bit acc, done;
      chk("byte_count", o_byte_count, m_bcnt);
      chk("word_count", o_word_wr_count, m_wcnt);
      if (stall) chk("mem_hold", {mem_we, mem_waddr, mem_wdata, mem_wstrb}, stall_snap);
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h strb 0x%0h, required none",
                   mem_waddr, mem_wdata, mem_wstrb);
        end else begin
          word_t e;
          e = exp_q.pop_front();
          chk("wr_addr", mem_waddr, e.addr);
          chk("wr_data", mem_wdata, e.data);
          chk("wr_strb", mem_wstrb, e.strb);
        end
        last_wr.addr = mem_waddr;
        last_wr.data = mem_wdata;
        last_wr.strb = mem_wstrb;
        hs_cyc = cyc;
        hs_cnt++;
      end
      stall      = mem_we && !mem_ready;
      stall_snap = {mem_we, mem_waddr, mem_wdata, mem_wstrb};
      if (flush_done) begin
        chk("flush_done_legal", {63'h0, flushing && !m_open && exp_q.size() == 0}, 64'h1);
        fd_cnt++;
        fd_cyc   = cyc;
        fd_bytes = o_byte_count;
        fd_words = o_word_wr_count;
      end

      acc  = in_we && in_ready;
      done = 1'b0;
      // A full word leaves on the first cycle the input could be accepted;
      // a same-word byte accepted on that cycle still joins it.
      if (model_full() && in_ready) begin
        if (acc && in_waddr[AW+1:2] == m_addr) begin
          m_byte[in_waddr[1:0]] = in_wdata;
          done = 1'b1;
        end
        close_word();
      end
      if (acc && !done) model_put(in_waddr[AW+1:2], in_waddr[1:0], in_wdata);
      if (flush_done) flushing = 1'b0;
      else if (flush && !flushing) begin
        if (m_open) close_word();
        flushing = 1'b1;
      end

      m_bcnt = flush_done ? 0 : m_bcnt + (acc ? 1 : 0);
      m_wcnt = flush_done ? 0 : m_wcnt + ((mem_we && mem_ready) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [AW+1:0] a, input logic [7:0] d);
    bit ok = 1'b0;
    int n  = 0;
    in_we    = 1'b1;
    in_waddr = a;
    in_wdata = d;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      step();
      n++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: byte to 0x%0h never accepted, required acceptance", a);
    end
    in_we = 1'b0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
  endtask

  task automatic wait_fd(input int c0);
    int n = 0;
    while (fd_cnt == c0 && n < 300) begin
      step();
      n++;
    end
    if (fd_cnt == c0) begin
      checks++;
      errors++;
      $display("FAIL flush_timeout: flush_done not seen, required within 300 cycles");
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_waddr", mem_waddr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_mem_wstrb", mem_wstrb, 0);
    chk("rst_byte_count", o_byte_count, 0);
    chk("rst_word_count", o_word_wr_count, 0);
  endtask

  initial begin
    int c0, h0;
    logic [AW-1:0] cur_word;
    rst       = 1'b1;
    in_we     = 1'b0;
    in_waddr  = '0;
    in_wdata  = '0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    fd_cnt    = 0;
    hs_cnt    = 0;
    #1;
    check_reset_outputs();
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_before_first_clk", in_ready, 0);
    step();
    @(negedge clk);
    chk("ready_after_first_clk", in_ready, 1);
    step();

    // Full word, latency of two cycles from the last byte.
    for (int i = 0; i < 4; i++) send(12'h010 + 12'(i), 8'hA0 + 8'(i));
    @(negedge clk);
    chk("lat_t1_mem_we", mem_we, 0);
    step();
    @(negedge clk);
    chk("lat_t2_mem_we", mem_we, 1);
    chk("lat_waddr", mem_waddr, 10'h004);
    chk("lat_wstrb", mem_wstrb, 4'hF);
    chk("lat_wdata", mem_wdata, 32'hA3A2A1A0);
    step();

    // Word change evicts a partial word.
    send(12'h010, 8'h11);
    send(12'h011, 8'h22);
    send(12'h020, 8'h33);
    repeat (3) step();
    chk("evict_addr", last_wr.addr, 10'h004);
    chk("evict_strb", last_wr.strb, 4'h3);
    chk("evict_data", last_wr.data, 32'h00002211);
    c0 = fd_cnt;
    pulse_flush();
    wait_fd(c0);
    chk("evict_flush_addr", last_wr.addr, 10'h008);
    chk("evict_flush_data", last_wr.data, 32'h00000033);

    // Same lane written twice, last write wins; flush drains it.
    send(12'h005, 8'hAA);
    send(12'h005, 8'hBB);
    c0 = fd_cnt;
    h0 = hs_cnt;
    pulse_flush();
    wait_fd(c0);
    chk("dup_writes", hs_cnt - h0, 1);
    chk("dup_addr", last_wr.addr, 10'h001);
    chk("dup_strb", last_wr.strb, 4'h2);
    chk("dup_data", last_wr.data, 32'h0000BB00);
    chk("dup_fd_after_hs", fd_cyc - hs_cyc, 1);
    chk("dup_fd_bytes", fd_bytes, 2);
    chk("dup_fd_words", fd_words, 1);
    @(negedge clk);
    chk("dup_bytes_cleared", o_byte_count, 0);
    step();

    // Memory backpressure with a new-word byte waiting.
    mem_ready = 1'b0;
    send(12'h040, 8'h01);
    send(12'h041, 8'h02);
    send(12'h044, 8'h03);
    in_we    = 1'b1;
    in_waddr = 12'h048;
    in_wdata = 8'h04;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      chk("bp_mem_we", mem_we, 1);
      chk("bp_waddr", mem_waddr, 10'h010);
      step();
    end
    mem_ready = 1'b1;
    send(12'h048, 8'h04);
    c0 = fd_cnt;
    pulse_flush();
    wait_fd(c0);
    chk("bp_last_addr", last_wr.addr, 10'h012);

    // Flush with nothing pending.
    repeat (2) step();
    h0    = hs_cnt;
    flush = 1'b1;
    @(negedge clk);
    chk("empty_fd_t0", flush_done, 0);
    step();
    flush = 1'b0;
    @(negedge clk);
    chk("empty_fd_t1", flush_done, 1);
    step();
    chk("empty_no_write", hs_cnt - h0, 0);

    // Reset with three bytes buffered.
    send(12'h080, 8'h51);
    send(12'h081, 8'h52);
    send(12'h082, 8'h53);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    repeat (2) step();
    rst = 1'b0;
    h0  = hs_cnt;
    repeat (20) step();
    chk("rst_no_write", hs_cnt - h0, 0);

    // Randomized traffic with backpressure and sporadic flushes.
    cur_word = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) < 3) begin
        cur_word = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      end
      in_we     = ($urandom_range(0, 3) != 0);
      in_waddr  = {cur_word, 2'($urandom_range(0, 3))};
      in_wdata  = 8'($urandom);
      mem_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 59) == 0);
      step();
    end
    in_we     = 1'b0;
    flush     = 1'b0;
    mem_ready = 1'b1;
    for (int n = 0; n < 300 && flushing; n++) step();
    c0 = fd_cnt;
    pulse_flush();
    wait_fd(c0);
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_acc_empty", {63'h0, m_open}, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
